// File: rtl/riscy_pkg.sv
// rtl/riscy_pkg.sv - shared RV32I decode constants and ALU operation encodings
package riscy_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - instruction, writeback and ALU-issue signals of decode_stage
interface decode_stage_if;
    import riscy_pkg::*;

    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      funct3;
    logic            funct7;
    logic [4:0]      rd_addr;
    logic            illegal;

    // decode_stage side
    modport slave (
        input  instr_valid, instr, wb_en, wb_addr, wb_data, flush, ex_ready,
        output instr_ready, ex_valid, rs1, rs2, funct3, funct7, rd_addr, illegal
    );

    // fetch / writeback / ALU side
    modport master (
        output instr_valid, instr, wb_en, wb_addr, wb_data, flush, ex_ready,
        input  instr_ready, ex_valid, rs1, rs2, funct3, funct7, rd_addr, illegal
    );

endinterface

// File: rtl/decode_stage_regfile.sv
// rtl/decode_stage_regfile.sv - 2R1W register file, x0 reads zero, write-through bypass
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // next register contents: one write per cycle, x0 never written
    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0) begin
            regs_d[wa] = wd;
        end
    end

    // read ports see a same-cycle write so a waiting consumer can issue immediately
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) begin
            rd1 = (we && wa == ra1) ? wd : regs_q[ra1];
        end
        if (ra2 != 5'd0) begin
            rd2 = (we && wa == ra2) ? wd : regs_q[ra2];
        end
    end

    // storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I OP/OP-IMM decode, scoreboard and ALU issue register
module decode_stage
    import riscy_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);

    logic [6:0]      opcode;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [4:0]      rd_idx;
    logic [2:0]      f3;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic            is_op;
    logic            is_opi;
    logic            legal;
    logic [XLEN-1:0] rs2_val;
    logic            f7_val;
    logic            src1_busy;
    logic            src2_busy;
    logic            rd_busy;
    logic            hazard;
    logic            accept;

    logic [NREG-1:0] pending_q, pending_d;
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            funct7_q, funct7_d;
    logic [4:0]      rd_q, rd_d;
    logic            illegal_q, illegal_d;

    assign opcode  = bus.instr[6:0];
    assign rd_idx  = bus.instr[11:7];
    assign f3      = bus.instr[14:12];
    assign rs1_idx = bus.instr[19:15];
    assign rs2_idx = bus.instr[24:20];

    regfile #(
        .XLEN(XLEN),
        .NREG(NREG)
    ) u_regfile (
        .clk  (clk),
        .rst_n(rst_n),
        .ra1  (rs1_idx),
        .ra2  (rs2_idx),
        .rd1  (rf_rd1),
        .rd2  (rf_rd2),
        .we   (bus.wb_en),
        .wa   (bus.wb_addr),
        .wd   (bus.wb_data)
    );

    // decode the operand B source and detect RAW/WAW hazards against the scoreboard
    always_comb begin
        is_op  = (opcode == OPC_OP);
        is_opi = (opcode == OPC_OP_IMM);
        legal  = is_op || is_opi;

        if (is_op) begin
            rs2_val = rf_rd2;
        end else if (f3 == F3_SLL || f3 == F3_SR) begin
            rs2_val = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
        end else begin
            rs2_val = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
        end
        f7_val = is_op ? bus.instr[30] : ((f3 == F3_SR) && bus.instr[30]);

        // a writeback landing this cycle satisfies a waiting source through the bypass
        src1_busy = pending_q[rs1_idx] && !(bus.wb_en && bus.wb_addr == rs1_idx);
        src2_busy = pending_q[rs2_idx] && !(bus.wb_en && bus.wb_addr == rs2_idx);
        rd_busy   = pending_q[rd_idx];
        hazard    = legal && (src1_busy || (is_op && src2_busy) || rd_busy);
    end

    assign accept = bus.instr_valid && bus.instr_ready;

    // issue register and scoreboard next state
    always_comb begin
        ex_valid_d = ex_valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        rd_d       = rd_q;
        illegal_d  = illegal_q;
        pending_d  = pending_q;

        if (bus.wb_en && bus.wb_addr != 5'd0) begin
            pending_d[bus.wb_addr] = 1'b0;
        end
        // a flushed instruction will never write back, so release its destination
        if (bus.flush && ex_valid_q && !illegal_q && rd_q != 5'd0) begin
            pending_d[rd_q] = 1'b0;
        end

        if (accept) begin
            ex_valid_d = 1'b1;
            illegal_d  = !legal;
            rs1_d      = legal ? rf_rd1 : '0;
            rs2_d      = legal ? rs2_val : '0;
            funct3_d   = legal ? f3 : 3'd0;
            funct7_d   = legal ? f7_val : 1'b0;
            rd_d       = legal ? rd_idx : 5'd0;
            // set after the clears so a new claim wins over a same-cycle release
            if (legal && rd_idx != 5'd0) begin
                pending_d[rd_idx] = 1'b1;
            end
        end else if (bus.flush || bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end

        pending_d[0] = 1'b0;
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= 3'd0;
            funct7_q   <= 1'b0;
            rd_q       <= 5'd0;
            illegal_q  <= 1'b0;
            pending_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            rd_q       <= rd_d;
            illegal_q  <= illegal_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.instr_ready = (!ex_valid_q || bus.ex_ready) && !hazard && !bus.flush;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.rs1         = rs1_q;
    assign bus.rs2         = rs2_q;
    assign bus.funct3      = funct3_q;
    assign bus.funct7      = funct7_q;
    assign bus.rd_addr     = rd_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with a reference model
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if bus();

    decode_stage dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] rf[32];
    bit          pend[32];
    bit          held_legal;
    logic [4:0]  held_rd;
    int          errors = 0;
    int          checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        q.delete();
        for (int i = 0; i < 32; i++) begin
            rf[i] = '0;
            pend[i] = 1'b0;
        end
        held_legal = 1'b0;
        held_rd = '0;
    endfunction

    function automatic logic [31:0] src(logic [4:0] idx, logic wbe, logic [4:0] wba, logic [31:0] wbd);
        if (idx == 0) return 32'd0;
        if (wbe && wba == idx) return wbd;
        return rf[idx];
    endfunction

    function automatic exp_t ref_decode(logic [31:0] ins, logic wbe, logic [4:0] wba, logic [31:0] wbd);
        exp_t e;
        logic [2:0] f3;
        e  = '0;
        f3 = ins[14:12];
        if (ins[6:0] == 7'h33) begin
            e.rs1 = src(ins[19:15], wbe, wba, wbd);
            e.rs2 = src(ins[24:20], wbe, wba, wbd);
            e.f3  = f3;
            e.f7  = ins[30];
            e.rd  = ins[11:7];
        end else if (ins[6:0] == 7'h13) begin
            e.rs1 = src(ins[19:15], wbe, wba, wbd);
            if (f3 == 3'd1 || f3 == 3'd5) e.rs2 = 32'(ins[24:20]);
            else                          e.rs2 = 32'($signed(ins[31:20]));
            e.f3  = f3;
            e.f7  = (f3 == 3'd5) ? ins[30] : 1'b0;
            e.rd  = ins[11:7];
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic bit busy_src(logic [4:0] idx, logic wbe, logic [4:0] wba);
        return idx != 0 && pend[idx] && !(wbe && wba == idx);
    endfunction

    function automatic bit ref_stall(logic [31:0] ins, logic wbe, logic [4:0] wba);
        bit op, opi;
        op  = ins[6:0] == 7'h33;
        opi = ins[6:0] == 7'h13;
        if (!(op || opi)) return 1'b0;
        return busy_src(ins[19:15], wbe, wba) || (op && busy_src(ins[24:20], wbe, wba)) ||
               (ins[11:7] != 0 && pend[ins[11:7]]);
    endfunction

    // one cycle of stimulus, entered and left 1 time unit after a rising edge
    task automatic step(input logic iv, input logic [31:0] ins, input logic wbe, input logic [4:0] wba,
                        input logic [31:0] wbd, input logic fl, input logic exr);
        bit   was_valid, rdy;
        exp_t e;
        bus.instr_valid = iv;
        bus.instr       = ins;
        bus.wb_en       = wbe;
        bus.wb_addr     = wba;
        bus.wb_data     = wbd;
        bus.flush       = fl;
        bus.ex_ready    = exr;
        #1;
        was_valid = q.size() != 0;
        rdy = (!was_valid || exr) && !ref_stall(ins, wbe, wba) && !fl;
        e   = ref_decode(ins, wbe, wba, wbd);
        chk("instr_ready", 32'(bus.instr_ready), 32'(rdy));
        @(posedge clk);
        if (wbe && wba != 0) begin
            rf[wba]   = wbd;
            pend[wba] = 1'b0;
        end
        if (fl && was_valid && held_legal && held_rd != 0) pend[held_rd] = 1'b0;
        if (iv && rdy) begin
            q.push_back(e);
            held_legal = !e.ill;
            held_rd    = e.rd;
            if (!e.ill && e.rd != 0) pend[e.rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic issue(input logic [31:0] ins);
        step(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 32'd0, 1'b1, a, d, 1'b0, 1'b1);
    endtask

    task automatic check_outputs_zero();
        chk("rst ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst rs1", bus.rs1, 32'd0);
        chk("rst rs2", bus.rs2, 32'd0);
        chk("rst funct3", 32'(bus.funct3), 32'd0);
        chk("rst funct7", 32'(bus.funct7), 32'd0);
        chk("rst rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst illegal", 32'(bus.illegal), 32'd0);
    endtask

    // monitor: the held output must always equal the oldest expected issue
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ex_valid", 32'(bus.ex_valid), 32'(q.size() != 0));
            if (bus.ex_valid && q.size() != 0) begin
                chk("rs1", bus.rs1, q[0].rs1);
                chk("rs2", bus.rs2, q[0].rs2);
                chk("funct3", 32'(bus.funct3), 32'(q[0].f3));
                chk("funct7", 32'(bus.funct7), 32'(q[0].f7));
                chk("rd_addr", 32'(bus.rd_addr), 32'(q[0].rd));
                chk("illegal", 32'(bus.illegal), 32'(q[0].ill));
                if (bus.ex_ready || bus.flush) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [2:0]  f3;
        int          r;

        model_clear();
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
        bus.ex_ready    = 1'b1;
        #3;
        check_outputs_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // addi x1,x0,20
        issue(32'h01400093);
        wb(5'd1, 32'd8);
        wb(5'd2, 32'd3);
        // sub x3,x1,x2 then add x4,x3,x3 stalls until x3 writes back
        issue(32'h402081B3);
        issue(32'h00318233);
        issue(32'h00318233);
        step(1'b1, 32'h00318233, 1'b1, 5'd3, 32'd50, 1'b0, 1'b1);
        wb(5'd4, 32'd100);
        // srai x5,x1,3 then srli x5,x1,3 (WAW on x5)
        issue(32'h4030D293);
        step(1'b1, 32'h0030D293, 1'b1, 5'd5, 32'd1, 1'b0, 1'b1);
        issue(32'h0030D293);
        wb(5'd5, 32'd2);
        // hold the ALU side for three cycles with a new instruction waiting
        step(1'b1, 32'h00500393, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h00900413, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        issue(32'h00900413);
        idle();
        // illegal opcode, then flush a held add x6 and reuse x6 as a source
        issue(32'h0000006F);
        step(1'b1, 32'h00208333, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        issue(32'h006304B3);
        idle();
        // add x10,x9,x9 stalls on x9, then reset arrives mid-stall
        issue(32'h00948533);
        issue(32'h00948533);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero();
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            r  = int'($urandom_range(0, 9));
            f3 = 3'($urandom_range(0, 7));
            ins = $urandom;
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[14:12] = f3;
            ins[19:15] = 5'($urandom_range(0, 7));
            if (r <= 4) begin
                ins[6:0]   = 7'h33;
                ins[24:20] = 5'($urandom_range(0, 7));
            end else if (r <= 8) begin
                ins[6:0] = 7'h13;
            end else if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
                ins[6:0] = 7'h6F;
            end
            step(1'($urandom_range(0, 9) < 8), ins,
                 1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
